// File: rtl/spi_tx_responder_pkg.sv
// Shared definitions for the SPI MISO transmit path.
//   WORD_W_DEF    : default bits per transmitted word
//   IDLE_WORD_DEF : default word sent when nothing is queued at word start
//   spiTxState_t  : transmit FSM state encoding
package spiPkg;

    localparam int          WORD_W_DEF    = 16;
    localparam logic [15:0] IDLE_WORD_DEF = 16'h0000;

    typedef enum logic {
        IDLE,
        SHIFT
    } spiTxState_t;

endpackage

// File: rtl/spi_tx_fifo.sv
// Synchronous FIFO holding words waiting to be shifted out on MISO.
//   clk, reset : system clock, synchronous active-low reset
//   push       : write pushData (ignored when full)
//   pushData   : word to enqueue
//   pop        : drop the head word (ignored when empty)
//   head       : current head word (peek, valid when !empty)
//   count      : occupancy, 0..DEPTH
//   full,empty : occupancy flags
module spi_tx_fifo
    import spiPkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WORD_W-1:0]        pushData,
    input  logic                     pop,
    output logic [WORD_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wrPtr;
    logic [AW-1:0]     rdPtr;
    logic              doPush;
    logic              doPop;

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign head   = mem[rdPtr];

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/synchronizer.sv
// Two-flop synchronizer for asynchronous single-bit inputs, shared by the
// SPI receive and transmit paths.
//   clk   : destination clock
//   reset : synchronous active-low reset, loads RESET_VAL into both flops
//   d     : asynchronous input
//   q     : synchronized output, two clk of latency
module synchronizer #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_p0;
    logic sync_p1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_p0 <= RESET_VAL;
            sync_p1 <= RESET_VAL;
        end else begin
            meta_p0 <= d;
            sync_p1 <= meta_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/spi_tx_responder.sv
// SPI mode-0 MISO transmitter: internal logic queues words through a
// valid/ready handshake; they are shifted out MSB-first while cs is low.
//   clk       : system clock, at least 8x sck
//   reset     : synchronous active-low reset
//   sck, cs   : raw asynchronous SPI clock and active-low chip select
//   txData    : word to enqueue, accepted when txValid && txReady
//   txValid   : txData valid
//   txReady   : FIFO not full
//   sdo       : serial data to the MCU
//   sdoEn     : pad output enable, high while synchronized cs is low
//   busy      : FSM in SHIFT
//   txDone    : pulse, a word had all bits sampled
//   underrun  : pulse, IDLE_WORD committed because the FIFO was empty
//   abort     : pulse, cs rose part way through a word
//   fifoCount : FIFO occupancy
module spi_tx_responder
    import spiPkg::*;
#(
    parameter int                WORD_W    = WORD_W_DEF,
    parameter int                DEPTH     = 4,
    parameter logic [WORD_W-1:0] IDLE_WORD = WORD_W'(IDLE_WORD_DEF)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sck,
    input  logic                   cs,
    input  logic [WORD_W-1:0]      txData,
    input  logic                   txValid,
    output logic                   txReady,
    output logic                   sdo,
    output logic                   sdoEn,
    output logic                   busy,
    output logic                   txDone,
    output logic                   underrun,
    output logic                   abort,
    output logic [$clog2(DEPTH):0] fifoCount
);

    localparam int BW = $clog2(WORD_W + 1);

    logic              sckS, csS;
    logic              sckPrev_p2, csPrev_p2;
    logic              sckRise_p3, sckFall_p3, csRise_p3, csFall_p3;

    spiTxState_t       state, state_n;
    logic [WORD_W-1:0] shreg, shreg_n;
    logic [BW-1:0]     bitCnt, bitCnt_n;
    logic              fromFifo, fromFifo_n;
    logic              sdo_n, txDone_n, underrun_n, abort_n;

    logic              pop;
    logic [WORD_W-1:0] head;
    logic              full, empty;
    logic [WORD_W-1:0] wordSrc;

    synchronizer #(.RESET_VAL(1'b0)) u_sck_sync (
        .clk(clk), .reset(reset), .d(sck), .q(sckS)
    );

    synchronizer #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk(clk), .reset(reset), .d(cs), .q(csS)
    );

    spi_tx_fifo #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (txValid),
        .pushData (txData),
        .pop      (pop),
        .head     (head),
        .count    (fifoCount),
        .full     (full),
        .empty    (empty)
    );

    // Edge strobes are registered so each lands exactly one clk wide.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sckPrev_p2 <= 1'b0;
            csPrev_p2  <= 1'b1;
            sckRise_p3 <= 1'b0;
            sckFall_p3 <= 1'b0;
            csRise_p3  <= 1'b0;
            csFall_p3  <= 1'b0;
        end else begin
            sckPrev_p2 <= sckS;
            csPrev_p2  <= csS;
            sckRise_p3 <= sckS & ~sckPrev_p2;
            sckFall_p3 <= ~sckS & sckPrev_p2;
            csRise_p3  <= csS & ~csPrev_p2;
            csFall_p3  <= ~csS & csPrev_p2;
        end
    end

    // Peek only; the pop happens when the first bit is actually sampled.
    assign wordSrc = empty ? IDLE_WORD : head;
    assign txReady = !full;
    assign sdoEn   = ~csS;
    assign busy    = (state == SHIFT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            bitCnt   <= '0;
            fromFifo <= 1'b0;
            sdo      <= 1'b0;
            txDone   <= 1'b0;
            underrun <= 1'b0;
            abort    <= 1'b0;
        end else begin
            state    <= state_n;
            bitCnt   <= bitCnt_n;
            fromFifo <= fromFifo_n;
            sdo      <= sdo_n;
            txDone   <= txDone_n;
            underrun <= underrun_n;
            abort    <= abort_n;
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_n;
    end

    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        bitCnt_n   = bitCnt;
        fromFifo_n = fromFifo;
        sdo_n      = sdo;
        txDone_n   = 1'b0;
        underrun_n = 1'b0;
        abort_n    = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                sdo_n = 1'b0;
                if (csFall_p3) begin
                    state_n    = SHIFT;
                    shreg_n    = wordSrc;
                    fromFifo_n = !empty;
                    bitCnt_n   = '0;
                    sdo_n      = wordSrc[WORD_W-1];
                end
            end
            SHIFT: begin
                // cs strobes win over a coincident sck strobe.
                if (csRise_p3) begin
                    state_n  = IDLE;
                    sdo_n    = 1'b0;
                    bitCnt_n = '0;
                    abort_n  = (bitCnt != '0) && (bitCnt != BW'(WORD_W));
                end else if (sckRise_p3) begin
                    if (bitCnt != BW'(WORD_W)) begin
                        if (bitCnt == '0) begin
                            pop        = fromFifo;
                            underrun_n = !fromFifo;
                        end
                        bitCnt_n = bitCnt + BW'(1);
                        txDone_n = (bitCnt_n == BW'(WORD_W));
                    end
                end else if (sckFall_p3) begin
                    if (bitCnt == BW'(WORD_W)) begin
                        shreg_n    = wordSrc;
                        fromFifo_n = !empty;
                        bitCnt_n   = '0;
                        sdo_n      = wordSrc[WORD_W-1];
                    end else if (bitCnt != '0) begin
                        shreg_n = shreg << 1;
                        sdo_n   = shreg[WORD_W-2];
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_tx_responder.sv
module tb_spi_tx_responder;

    localparam logic [15:0] IDLE_W = 16'h0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sck = 1'b0;
    logic        cs = 1'b1;
    logic [15:0] txData = '0;
    logic        txValid = 1'b0;
    logic        txReady, sdo, sdoEn, busy, txDone, underrun, abort;
    logic [2:0]  fifoCount;

    int nChecks = 0;
    int nErrors = 0;
    int nDone = 0, nUnder = 0, nAbort = 0;
    logic [15:0] expQ[$];

    spi_tx_responder dut (
        .clk(clk), .reset(reset), .sck(sck), .cs(cs),
        .txData(txData), .txValid(txValid), .txReady(txReady),
        .sdo(sdo), .sdoEn(sdoEn), .busy(busy), .txDone(txDone),
        .underrun(underrun), .abort(abort), .fifoCount(fifoCount)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (txDone)   nDone  = nDone + 1;
        if (underrun) nUnder = nUnder + 1;
        if (abort)    nAbort = nAbort + 1;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks = nChecks + 1;
        if (obs !== exp) begin
            nErrors = nErrors + 1;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] w, output bit acc);
        @(negedge clk);
        txData  = w;
        txValid = 1'b1;
        acc     = txReady;
        if (acc) expQ.push_back(w);
        @(negedge clk);
        txValid = 1'b0;
    endtask

    // MCU model: ncyc mode-0 sck cycles at 16 clk per sck. cntFirst >= 0 checks
    // occupancy after the first rising strobe; inject pushes injW in the clk
    // where that strobe pops the head.
    task automatic xfer(input int ncyc, input int cntFirst, input bit inject, input logic [15:0] injW);
        logic [15:0] rx = '0;
        logic [15:0] e;
        int nb = 0;
        @(negedge clk);
        cs = 1'b0;
        repeat (8) @(negedge clk);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            rx  = {rx[14:0], sdo};
            nb  = nb + 1;
            sck = 1'b1;
            for (int k = 1; k < 8; k++) begin
                @(negedge clk);
                if (c == 0 && inject && k == 3) begin
                    txData  = injW;
                    txValid = 1'b1;
                    expQ.push_back(injW);
                end
                if (c == 0 && inject && k == 4) begin
                    txValid = 1'b0;
                    chk("cnt_push_pop", 32'(fifoCount), 32'(cntFirst));
                end
                if (c == 0 && !inject && k == 5 && cntFirst >= 0)
                    chk("cnt_first_rise", 32'(fifoCount), 32'(cntFirst));
            end
            if (nb == 16) begin
                e  = (expQ.size() > 0) ? expQ.pop_front() : IDLE_W;
                chk("rx_word", 32'(rx), 32'(e));
                nb = 0;
            end
            @(negedge clk);
            sck = 1'b0;
            repeat (7) @(negedge clk);
        end
        @(negedge clk);
        cs = 1'b1;
        if (nb > 0 && expQ.size() > 0) void'(expQ.pop_front());
        repeat (10) @(negedge clk);
    endtask

    initial begin
        bit acc;
        int d0, u0, a0;

        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_sdo", 32'(sdo), 0);
        chk("rst_sdoEn", 32'(sdoEn), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_txReady", 32'(txReady), 1);
        chk("rst_count", 32'(fifoCount), 0);
        chk("rst_pulses", 32'({txDone, underrun, abort}), 0);

        // Single word
        push(16'hA5C3, acc);
        chk("single_cnt0", 32'(fifoCount), 1);
        d0 = nDone; u0 = nUnder; a0 = nAbort;
        xfer(16, 0, 1'b0, '0);
        chk("single_done", 32'(nDone - d0), 1);
        chk("single_under", 32'(nUnder - u0), 0);
        chk("single_abort", 32'(nAbort - a0), 0);
        chk("single_cnt_end", 32'(fifoCount), 0);

        // Empty FIFO
        d0 = nDone; u0 = nUnder;
        xfer(16, 0, 1'b0, '0);
        chk("empty_under", 32'(nUnder - u0), 1);
        chk("empty_done", 32'(nDone - d0), 1);
        chk("empty_cnt", 32'(fifoCount), 0);

        // Streaming three words in one cs window
        push(16'h1234, acc);
        push(16'h5678, acc);
        push(16'h9ABC, acc);
        d0 = nDone; u0 = nUnder;
        xfer(48, 2, 1'b0, '0);
        chk("stream_done", 32'(nDone - d0), 3);
        chk("stream_under", 32'(nUnder - u0), 0);
        chk("stream_cnt", 32'(fifoCount), 0);

        // Abort mid-word
        push(16'hFFFF, acc);
        push(16'h0001, acc);
        a0 = nAbort;
        xfer(7, 1, 1'b0, '0);
        chk("abort_pulse", 32'(nAbort - a0), 1);
        chk("abort_cnt", 32'(fifoCount), 1);
        xfer(16, 0, 1'b0, '0);
        chk("abort_after_cnt", 32'(fifoCount), 0);
        chk("abort_after_pulse", 32'(nAbort - a0), 1);

        // Backpressure
        for (int i = 0; i < 5; i++) begin
            push(16'hC000 + 16'(i), acc);
            if (i == 3) chk("full_ready", 32'(txReady), 0);
            if (i == 4) chk("full_refused", 32'(acc), 0);
        end
        chk("full_cnt", 32'(fifoCount), 4);
        xfer(64, 3, 1'b0, '0);
        chk("drain_cnt", 32'(fifoCount), 0);

        // Push and pop in the same clk
        push(16'h0F0F, acc);
        push(16'hF0F0, acc);
        xfer(48, 2, 1'b1, 16'h3C3C);
        chk("pushpop_end_cnt", 32'(fifoCount), 0);

        // Reset mid-word
        push(16'hAAAA, acc);
        push(16'hBBBB, acc);
        push(16'hCCCC, acc);
        @(negedge clk);
        cs = 1'b0;
        repeat (8) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); sck = 1'b1;
            repeat (7) @(negedge clk);
            @(negedge clk); sck = 1'b0;
            repeat (7) @(negedge clk);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("rstmid_sdo", 32'(sdo), 0);
        chk("rstmid_sdoEn", 32'(sdoEn), 0);
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_cnt", 32'(fifoCount), 0);
        chk("rstmid_ready", 32'(txReady), 1);
        expQ.delete();
        @(negedge clk);
        cs = 1'b1;
        repeat (12) @(negedge clk);
        u0 = nUnder;
        xfer(16, 0, 1'b0, '0);
        chk("rstmid_under", 32'(nUnder - u0), 1);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
